// File: rtl/ft_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ft_pkg
// Description : Shared constants for the FT transmit path: arbiter state
//               encodings, default channel header bytes and the grant helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ft_pkg;

  // Arbiter state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] CSUM = 2'd3;

  // Default packet header bytes
  localparam logic [7:0] c_HDR_CH0_DEFAULT = 8'hA0;  // command replies
  localparam logic [7:0] c_HDR_CH1_DEFAULT = 8'hA1;  // CCD pixel stream

  // Channel to grant out of IDLE. A lone requester always wins; when both
  // request, the channel that did not win last time goes first.
  function automatic logic pick_grant(input logic v0, input logic v1,
                                      input logic last_grant);
    if (v0 && v1) return ~last_grant;
    return v1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ft_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ft_tx_arbiter
// Description : Merges two byte streams into framed packets for the tx FIFO.
//               Each packet is: header byte, 1..MAX_LEN data bytes, XOR
//               checksum of header and data. Packets are atomic; channel
//               choice alternates when both request.
// Ports       : clk, rst_n          - clock, async active-low reset
//               s0_* / s1_*         - channel byte streams (valid/ready/last)
//               tx_wdata, tx_winc   - tx FIFO write side
//               tx_wfull            - tx FIFO full, stalls all writes
//               busy                - packet in progress
//               len_err             - sticky truncation flag
//               len_err_clr         - clears len_err (a new truncation wins)
// Revision    : 1.0 - initial release
// ============================================================================
module ft_tx_arbiter
  import ft_pkg::*;
#(
  parameter logic [7:0] HDR_CH0 = c_HDR_CH0_DEFAULT,
  parameter logic [7:0] HDR_CH1 = c_HDR_CH1_DEFAULT,
  parameter int         MAX_LEN = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] tx_wdata,
  output logic       tx_winc,
  input  logic       tx_wfull,
  output logic       busy,
  output logic       len_err,
  input  logic       len_err_clr
);

  logic [1:0] r_state;
  logic       r_gnt;         // channel owning the current packet
  logic       r_last_grant;
  logic [7:0] r_count;
  logic [7:0] r_csum;
  logic       r_len_err;

  logic [7:0] w_gnt_data;
  logic       w_gnt_valid;
  logic       w_gnt_last;
  logic [7:0] w_hdr;
  logic       w_data_ready;
  logic       w_fire;
  logic [8:0] w_count_next;
  logic       w_at_max;
  logic       w_trunc;
  logic       w_new_gnt;

  assign w_gnt_data  = r_gnt ? s1_data  : s0_data;
  assign w_gnt_valid = r_gnt ? s1_valid : s0_valid;
  assign w_gnt_last  = r_gnt ? s1_last  : s0_last;
  assign w_hdr       = r_gnt ? HDR_CH1  : HDR_CH0;

  // Only the granted channel may see ready, and only while the FIFO has room.
  assign w_data_ready = (r_state == DATA) && !tx_wfull;
  assign s0_ready     = w_data_ready && !r_gnt;
  assign s1_ready     = w_data_ready &&  r_gnt;
  assign w_fire       = w_data_ready && w_gnt_valid;

  // Nine bits so the compare is exact even with MAX_LEN = 255.
  assign w_count_next = {1'b0, r_count} + 9'd1;
  assign w_at_max     = (w_count_next == 9'(MAX_LEN));
  assign w_trunc      = w_fire && !w_gnt_last && w_at_max;

  assign w_new_gnt = pick_grant(s0_valid, s1_valid, r_last_grant);

  assign busy    = (r_state != IDLE);
  assign len_err = r_len_err;

  always_comb begin
    tx_winc  = 1'b0;
    tx_wdata = 8'h00;
    case (r_state)
      HDR: begin
        if (!tx_wfull) begin
          tx_winc  = 1'b1;
          tx_wdata = w_hdr;
        end
      end
      DATA: begin
        if (w_fire) begin
          tx_winc  = 1'b1;
          tx_wdata = w_gnt_data;
        end
      end
      CSUM: begin
        if (!tx_wfull) begin
          tx_winc  = 1'b1;
          tx_wdata = r_csum;
        end
      end
      default: begin
        tx_winc  = 1'b0;
        tx_wdata = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
      r_count      <= 8'd0;
      r_csum       <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s0_valid || s1_valid) begin
            r_gnt        <= w_new_gnt;
            r_last_grant <= w_new_gnt;
            r_state      <= HDR;
          end
        end
        HDR: begin
          if (!tx_wfull) begin
            r_csum  <= w_hdr;
            r_count <= 8'd0;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_fire) begin
            r_csum  <= r_csum ^ w_gnt_data;
            r_count <= w_count_next[7:0];
            // A truncated packet simply ends here; the rest of the source
            // packet re-enters arbitration as a fresh packet.
            if (w_gnt_last || w_at_max) r_state <= CSUM;
          end
        end
        CSUM: begin
          if (!tx_wfull) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_err <= 1'b0;
    end else if (w_trunc) begin
      r_len_err <= 1'b1;
    end else if (len_err_clr) begin
      r_len_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ft_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ft_tx_arbiter
// Description : Self-checking bench for ft_tx_arbiter. A packet-level model
//               predicts every tx byte, ready and busy value; directed
//               scenarios compare the captured tx byte log against
//               hand-built expected streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ft_tx_arbiter;

  localparam int         c_MAX_LEN = 4;
  localparam logic [7:0] c_H0      = 8'hA0;
  localparam logic [7:0] c_H1      = 8'hA1;

  localparam int P_IDLE = 0;
  localparam int P_HDR  = 1;
  localparam int P_DATA = 2;
  localparam int P_CSUM = 3;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sd[2];
  logic       sv[2];
  logic       sl[2];
  logic       sr[2];
  logic       s0_ready, s1_ready;
  logic [7:0] tx_wdata;
  logic       tx_winc;
  logic       tx_wfull;
  logic       busy;
  logic       len_err;
  logic       len_err_clr;

  always #5 clk = ~clk;

  ft_tx_arbiter #(
    .HDR_CH0 (c_H0),
    .HDR_CH1 (c_H1),
    .MAX_LEN (c_MAX_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s0_data     (sd[0]),
    .s0_valid    (sv[0]),
    .s0_last     (sl[0]),
    .s0_ready    (s0_ready),
    .s1_data     (sd[1]),
    .s1_valid    (sv[1]),
    .s1_last     (sl[1]),
    .s1_ready    (s1_ready),
    .tx_wdata    (tx_wdata),
    .tx_winc     (tx_winc),
    .tx_wfull    (tx_wfull),
    .busy        (busy),
    .len_err     (len_err),
    .len_err_clr (len_err_clr)
  );

  // Source byte queues and captured tx stream
  beat_t      src_q[2][$];
  logic [7:0] tx_log[$];
  logic [7:0] exp_log[$];

  // Packet-level model
  int         m_phase;
  int         m_ch;
  int         m_last_grant;
  int         m_cnt;
  logic [7:0] m_csum;
  logic       m_len_err;

  int valid_pct, full_pct, clr_pct;
  int busy_cnt, winc_cnt;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hdr_of(input int ch);
    return (ch == 1) ? c_H1 : c_H0;
  endfunction

  task automatic add_bytes(input int n, input logic [7:0] first, input int len);
    for (int i = 0; i < len; i++)
      src_q[n].push_back('{d: first + 8'(i), last: (i == len - 1)});
  endtask

  task automatic add_rand_pkt(input int n, input int len);
    for (int i = 0; i < len; i++)
      src_q[n].push_back('{d: 8'($urandom), last: (i == len - 1)});
  endtask

  task automatic model_reset();
    m_phase      = P_IDLE;
    m_ch         = 0;
    m_last_grant = 1;
    m_cnt        = 0;
    m_csum       = 8'h00;
    m_len_err    = 1'b0;
  endtask

  // Hold reset across one rising edge and check the forced output values.
  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    sv[0]       = 1'b0;
    sv[1]       = 1'b0;
    tx_wfull    = 1'b0;
    len_err_clr = 1'b0;
    #1;
    chk("rst_outputs", {s0_ready, s1_ready, tx_winc, busy, len_err}, 5'b0);
    chk("rst_wdata", tx_wdata, 8'h00);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // One clock: drive at the falling edge, check the settled outputs against
  // the model, then advance the model as if the next rising edge happened.
  task automatic step();
    logic  fire;
    logic  set_err;
    beat_t b;
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      if (src_q[n].size() > 0 && $urandom_range(0, 99) < valid_pct) begin
        sv[n] = 1'b1;
        sd[n] = src_q[n][0].d;
        sl[n] = src_q[n][0].last;
      end else begin
        sv[n] = 1'b0;
        sd[n] = 8'($urandom);
        sl[n] = 1'($urandom);
      end
    end
    tx_wfull    = ($urandom_range(0, 99) < full_pct);
    len_err_clr = ($urandom_range(0, 99) < clr_pct);
    #1;
    sr[0] = s0_ready;
    sr[1] = s1_ready;
    if (tx_winc) begin
      tx_log.push_back(tx_wdata);
      winc_cnt++;
    end
    if (busy) busy_cnt++;

    chk("winc_while_full", tx_winc & tx_wfull, 1'b0);
    chk("busy", busy, m_phase != P_IDLE);
    chk("len_err", len_err, m_len_err);

    set_err = 1'b0;
    case (m_phase)
      P_IDLE: begin
        chk("idle_winc", tx_winc, 1'b0);
        chk("idle_ready", {sr[1], sr[0]}, 2'b00);
        if (sv[0] || sv[1]) begin
          m_ch         = (sv[0] && sv[1]) ? 1 - m_last_grant : (sv[1] ? 1 : 0);
          m_last_grant = m_ch;
          m_phase      = P_HDR;
        end
      end
      P_HDR: begin
        chk("hdr_winc", tx_winc, !tx_wfull);
        chk("hdr_ready", {sr[1], sr[0]}, 2'b00);
        if (!tx_wfull) begin
          chk("hdr_byte", tx_wdata, hdr_of(m_ch));
          m_csum  = hdr_of(m_ch);
          m_cnt   = 0;
          m_phase = P_DATA;
        end
      end
      P_DATA: begin
        chk("data_ready_gnt", sr[m_ch], !tx_wfull);
        chk("data_ready_other", sr[1 - m_ch], 1'b0);
        fire = sv[m_ch] && !tx_wfull;
        chk("data_winc", tx_winc, fire);
        if (fire) begin
          b = src_q[m_ch].pop_front();
          chk("data_byte", tx_wdata, b.d);
          m_csum = m_csum ^ b.d;
          m_cnt++;
          if (b.last) begin
            m_phase = P_CSUM;
          end else if (m_cnt == c_MAX_LEN) begin
            m_phase = P_CSUM;
            set_err = 1'b1;
          end
        end
      end
      default: begin
        chk("csum_winc", tx_winc, !tx_wfull);
        chk("csum_ready", {sr[1], sr[0]}, 2'b00);
        if (!tx_wfull) begin
          chk("csum_byte", tx_wdata, m_csum);
          m_phase = P_IDLE;
        end
      end
    endcase
    if (set_err)          m_len_err = 1'b1;
    else if (len_err_clr) m_len_err = 1'b0;
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, tx_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size(); i++)
      if (i < tx_log.size()) chk(tag, tx_log[i], exp_log[i]);
  endtask

  task automatic start_directed();
    src_q[0].delete();
    src_q[1].delete();
    do_reset();
    tx_log.delete();
    exp_log.delete();
    valid_pct = 100;
    full_pct  = 0;
    clr_pct   = 0;
    busy_cnt  = 0;
    winc_cnt  = 0;
  endtask

  initial begin
    int done;
    rst_n       = 1'b0;
    sv[0]       = 1'b0;
    sv[1]       = 1'b0;
    sd[0]       = 8'h00;
    sd[1]       = 8'h00;
    sl[0]       = 1'b0;
    sl[1]       = 1'b0;
    tx_wfull    = 1'b0;
    len_err_clr = 1'b0;
    model_reset();

    // Single short packet, minimum latency and busy width
    start_directed();
    add_bytes(0, 8'h11, 2);
    repeat (8) step();
    exp_log = '{8'hA0, 8'h11, 8'h12, 8'hA0 ^ 8'h11 ^ 8'h12};
    check_log("short_pkt");
    chk("short_pkt_busy_cycles", busy_cnt, 4);

    // Same shape with the 0x11/0x22 payload
    start_directed();
    src_q[0].push_back('{d: 8'h11, last: 1'b0});
    src_q[0].push_back('{d: 8'h22, last: 1'b1});
    repeat (8) step();
    exp_log = '{8'hA0, 8'h11, 8'h22, 8'hA0 ^ 8'h11 ^ 8'h22};
    check_log("pkt_11_22");

    // Both channels requesting at reset exit: channel 0 first, no interleave
    start_directed();
    add_bytes(0, 8'h61, 2);
    add_bytes(1, 8'h71, 2);
    repeat (14) step();
    exp_log = '{8'hA0, 8'h61, 8'h62, 8'hA0 ^ 8'h61 ^ 8'h62,
                8'hA1, 8'h71, 8'h72, 8'hA1 ^ 8'h71 ^ 8'h72};
    check_log("both_at_reset");

    // FIFO full for 5 cycles in the middle of a packet
    start_directed();
    add_bytes(0, 8'h81, 3);
    for (int i = 0; i < 20 && !(m_phase == P_DATA && m_cnt == 1); i++) step();
    chk("stall_reached_data", (m_phase == P_DATA && m_cnt == 1), 1'b1);
    full_pct = 100;
    winc_cnt = 0;
    repeat (5) step();
    chk("stall_no_winc", winc_cnt, 0);
    full_pct = 0;
    repeat (8) step();
    exp_log = '{8'hA0, 8'h81, 8'h82, 8'h83, 8'hA0 ^ 8'h81 ^ 8'h82 ^ 8'h83};
    check_log("stall_resume");

    // Six-byte source packet truncated at four bytes
    start_directed();
    add_bytes(1, 8'h51, 6);
    repeat (16) step();
    exp_log = '{8'hA1, 8'h51, 8'h52, 8'h53, 8'h54,
                8'hA1 ^ 8'h51 ^ 8'h52 ^ 8'h53 ^ 8'h54,
                8'hA1, 8'h55, 8'h56, 8'hA1 ^ 8'h55 ^ 8'h56};
    check_log("truncate");
    chk("truncate_len_err", len_err, 1'b1);
    clr_pct = 100;
    step();
    clr_pct = 0;
    step();
    chk("len_err_cleared", len_err, 1'b0);

    // Reset in the middle of DATA: no checksum, remainder is a fresh packet
    start_directed();
    add_bytes(0, 8'h31, 5);
    for (int i = 0; i < 20 && !(m_phase == P_DATA && m_cnt == 2); i++) step();
    chk("rst_mid_reached_data", (m_phase == P_DATA && m_cnt == 2), 1'b1);
    do_reset();
    tx_log.delete();
    repeat (10) step();
    exp_log = '{8'hA0, 8'h33, 8'h34, 8'h35, 8'hA0 ^ 8'h33 ^ 8'h34 ^ 8'h35};
    check_log("after_mid_reset");

    // 100 back-to-back packets per channel with random back-pressure
    start_directed();
    for (int i = 0; i < 100; i++) begin
      add_rand_pkt(0, $urandom_range(1, 3));
      add_rand_pkt(1, $urandom_range(1, 3));
    end
    full_pct = 20;
    clr_pct  = 5;
    done     = 0;
    for (int i = 0; i < 8000 && done == 0; i++) begin
      step();
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && m_phase == P_IDLE) done = 1;
    end
    chk("b2b_drained", done, 1);

    // Fully random traffic: gaps, truncations, clears
    start_directed();
    for (int i = 0; i < 60; i++) begin
      add_rand_pkt(0, $urandom_range(1, 7));
      add_rand_pkt(1, $urandom_range(1, 7));
    end
    valid_pct = 70;
    full_pct  = 25;
    clr_pct   = 3;
    done      = 0;
    for (int i = 0; i < 12000 && done == 0; i++) begin
      step();
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && m_phase == P_IDLE) done = 1;
    end
    chk("random_drained", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
